// File: rtl/uart_tx_param.sv
// uart_tx_param
// -------------
// Parametrised UART transmitter. A word accepted through a valid/ready
// handshake goes out on tx as one frame: a start bit, DATA_W data bits LSB
// first, an optional parity bit, then STOP_BITS stop bits. Each bit lasts
// CLKS_PER_BIT clock cycles, timed by an internal counter.
//
// Handshake: a transfer happens on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_ready is high only in IDLE. tx_valid seen in any
// other state is ignored, and tx_data is sampled only on the transfer edge.
//
// Parameters
//   DATA_W       data bits per frame (5..9)
//   CLKS_PER_BIT clk cycles per serial bit (>= 2)
//   PARITY_EN    1 = insert a parity bit after the data
//   PARITY_ODD   1 = odd parity, 0 = even parity
//   STOP_BITS    number of stop bits (1 or 2)
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   tx_data   word to transmit
//   tx_valid  tx_data is valid
//   tx_ready  block can accept a word (IDLE)
//   tx        registered serial output, idles high
//   busy      frame in progress (= !tx_ready)
//   done      one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;     // clocks within the current bit
    logic [IDX_W-1:0]  idx_q, idx_d;     // data-bit index, reused as stop-bit index
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ ODD;
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // tx is decoded from the next-cycle state so the registered line changes
    // on the same edge as the state, keeping every bit exactly one period.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign done     = done_q;

endmodule
